// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, coordinate/score/lives widths and game constants.
// Used by the collision controller and by the plane/lava/mountain movers and the draw path.
package game_pkg;

  localparam int COORD_W = 10;
  localparam int SCORE_W = 7;
  localparam int LIVES_W = 2;
  localparam int TIMER_W = 6;
  localparam int N_OBS   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_e;

  localparam logic [COORD_W-1:0] PLANE_X    = 10'd160;
  localparam logic [COORD_W-1:0] HIT_W      = 10'd16;
  localparam logic [COORD_W-1:0] HIT_H      = 10'd12;
  localparam logic [LIVES_W-1:0] LIVES_INIT = 2'd3;
  localparam logic [TIMER_W-1:0] INVULN_T   = 6'd30;
  localparam logic [SCORE_W-1:0] SCORE_MAX  = 7'd99;

  // Unsigned distance without going through a signed intermediate.
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic [1:0]         n);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + {{(SCORE_W-1){1'b0}}, n};
    if (sum > {1'b0, SCORE_MAX}) return SCORE_MAX;
    return sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/hit_box_cmp.sv
// Collision window test of one obstacle against the fixed-x plane. below_mode_i selects
// between a symmetric y box (lava drop) and "plane at or below the peak" (mountain).
module hit_box_cmp
  import game_pkg::*;
(
  input  logic [COORD_W-1:0] obj_x_i,
  input  logic [COORD_W-1:0] obj_y_i,
  input  logic [COORD_W-1:0] plane_y_i,
  input  logic               below_mode_i,
  output logic               hit_o
);

  logic x_in;
  logic y_in;

  assign x_in  = abs_diff(obj_x_i, PLANE_X) < HIT_W;
  assign y_in  = below_mode_i ? (plane_y_i >= obj_y_i)
                              : (abs_diff(obj_y_i, plane_y_i) < HIT_H);
  assign hit_o = x_in && y_in;

endmodule

// File: rtl/collision_game_ctrl.sv
// Top-level game FSM: samples obstacle positions on each frame tick, scores passes, handles
// hits/lives/invulnerability. Optional HIGH_SCORE_EN adds a best-score register and port.
module collision_game_ctrl
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [COORD_W-1:0] plane_y,
  input  logic [COORD_W-1:0] lava_x,
  input  logic [COORD_W-1:0] lava_y,
  input  logic [COORD_W-1:0] mtn1_x,
  input  logic [COORD_W-1:0] mtn1_y,
  input  logic [COORD_W-1:0] mtn2_x,
  input  logic [COORD_W-1:0] mtn2_y,
  output logic               game_over,
  output logic               hit_flash,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state
`ifdef HIGH_SCORE_EN
  ,
  output logic [SCORE_W-1:0] hi_score
`endif
);

  game_state_e                      state_q, state_d;
  logic        [LIVES_W-1:0]        lives_q, lives_d;
  logic        [SCORE_W-1:0]        score_q, score_d;
  logic        [TIMER_W-1:0]        timer_q, timer_d;
  logic [N_OBS-1:0][COORD_W-1:0]    prev_x_q, prev_x_d;
  logic                             armed_q, armed_d;
  logic                             game_over_q, game_over_d;
  logic                             hit_flash_q, hit_flash_d;

  logic [N_OBS-1:0][COORD_W-1:0]    obs_x;
  logic [N_OBS-1:0]                 obs_hit;
  logic                             hit_any;
  logic [1:0]                       pass_cnt;

  assign obs_x = {mtn2_x, mtn1_x, lava_x};

  hit_box_cmp u_hit_lava (
    .obj_x_i      (lava_x),
    .obj_y_i      (lava_y),
    .plane_y_i    (plane_y),
    .below_mode_i (1'b0),
    .hit_o        (obs_hit[0])
  );

  hit_box_cmp u_hit_mtn1 (
    .obj_x_i      (mtn1_x),
    .obj_y_i      (mtn1_y),
    .plane_y_i    (plane_y),
    .below_mode_i (1'b1),
    .hit_o        (obs_hit[1])
  );

  hit_box_cmp u_hit_mtn2 (
    .obj_x_i      (mtn2_x),
    .obj_y_i      (mtn2_y),
    .plane_y_i    (plane_y),
    .below_mode_i (1'b1),
    .hit_o        (obs_hit[2])
  );

  assign hit_any = |obs_hit;

  // Obstacles move leftwards; x jumping upwards means it respawned, i.e. the plane passed it.
  always_comb begin
    pass_cnt = 2'd0;
    for (int k = 0; k < N_OBS; k++) begin
      pass_cnt = pass_cnt + {1'b0, (obs_x[k] > prev_x_q[k])};
    end
  end

  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves a signal unassigned (no latches).
    state_d  = state_q;
    lives_d  = lives_q;
    score_d  = score_q;
    timer_d  = timer_q;
    prev_x_d = prev_x_q;
    armed_d  = armed_q | ~start;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (start && armed_q) begin
            state_d  = PLAY;
            lives_d  = LIVES_INIT;
            score_d  = '0;
            timer_d  = '0;
            prev_x_d = obs_x;
          end
        end
        PLAY: begin
          score_d  = sat_add(score_q, pass_cnt);
          prev_x_d = obs_x;
          if (hit_any) begin
            if (lives_q == 2'd1) begin
              state_d = OVER;
              lives_d = '0;
            end else begin
              state_d = HIT;
              lives_d = lives_q - 2'd1;
              timer_d = INVULN_T;
            end
          end
        end
        HIT: begin
          score_d  = sat_add(score_q, pass_cnt);
          prev_x_d = obs_x;
          timer_d  = timer_q - 6'd1;
          if (timer_q == 6'd1) state_d = PLAY;
        end
        OVER: begin
          // Leaving OVER disarms start so a held button cannot launch the next game.
          if (start) begin
            state_d = IDLE;
            armed_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    game_over_d = (state_d == IDLE) || (state_d == OVER);
    hit_flash_d = (state_d == HIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q     <= IDLE;
      lives_q     <= LIVES_INIT;
      score_q     <= '0;
      timer_q     <= '0;
      prev_x_q    <= '0;
      armed_q     <= 1'b1;
      game_over_q <= 1'b1;
      hit_flash_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      timer_q     <= timer_d;
      prev_x_q    <= prev_x_d;
      armed_q     <= armed_d;
      game_over_q <= game_over_d;
      hit_flash_q <= hit_flash_d;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] hi_score_q, hi_score_d;

  always_comb begin
    hi_score_d = hi_score_q;
    if ((state_q != OVER) && (state_d == OVER) && (score_d > hi_score_q)) begin
      hi_score_d = score_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hi_score_q <= '0;
    else       hi_score_q <= hi_score_d;
  end

  assign hi_score = hi_score_q;
`endif

  assign game_over = game_over_q;
  assign hit_flash = hit_flash_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign state     = state_q;

endmodule

// File: tb/tb_collision_game_ctrl.sv
// Self-checking bench for collision_game_ctrl: a behavioural game model checked every cycle,
// plus literal expectations at scenario milestones. Honors HIGH_SCORE_EN when defined.
module tb_collision_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       start;
  logic [9:0] plane_y, lava_x, lava_y, mtn1_x, mtn1_y, mtn2_x, mtn2_y;
  logic       game_over, hit_flash;
  logic [1:0] lives;
  logic [6:0] score;
  logic [1:0] state;
`ifdef HIGH_SCORE_EN
  logic [6:0] hi_score;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state (phase: 0 idle, 1 play, 2 hit, 3 over)
  int m_phase, m_lives, m_score, m_timer, m_armed, m_hi;
  int m_prev[3];

  always #5 clk = ~clk;

  collision_game_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .plane_y   (plane_y),
    .lava_x    (lava_x),
    .lava_y    (lava_y),
    .mtn1_x    (mtn1_x),
    .mtn1_y    (mtn1_y),
    .mtn2_x    (mtn2_x),
    .mtn2_y    (mtn2_y),
    .game_over (game_over),
    .hit_flash (hit_flash),
    .lives     (lives),
    .score     (score),
    .state     (state)
`ifdef HIGH_SCORE_EN
    ,
    .hi_score  (hi_score)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int adiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit model_hit();
    bit lava_hit, m1_hit, m2_hit;
    lava_hit = adiff(lava_x, 160) < 16 && adiff(lava_y, plane_y) < 12;
    m1_hit   = adiff(mtn1_x, 160) < 16 && plane_y >= mtn1_y;
    m2_hit   = adiff(mtn2_x, 160) < 16 && plane_y >= mtn2_y;
    return lava_hit || m1_hit || m2_hit;
  endfunction

  // Game model: evaluated at each rising clock edge from the spec's rules.
  initial begin
    int xs[3];
    int passes;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_phase = 0; m_lives = 3; m_score = 0; m_timer = 0; m_armed = 1; m_hi = 0;
        foreach (m_prev[k]) m_prev[k] = 0;
      end else begin
        xs[0] = lava_x; xs[1] = mtn1_x; xs[2] = mtn2_x;
        if (tick) begin
          if (m_phase == 0) begin
            if (start && m_armed) begin
              m_phase = 1; m_lives = 3; m_score = 0;
              foreach (xs[k]) m_prev[k] = xs[k];
            end
          end else if (m_phase == 3) begin
            if (start) begin
              m_phase = 0;
              m_armed = 0;
            end
          end else begin
            passes = 0;
            foreach (xs[k]) if (xs[k] > m_prev[k]) passes++;
            m_score = (m_score + passes > 99) ? 99 : m_score + passes;
            foreach (xs[k]) m_prev[k] = xs[k];
            if (m_phase == 1) begin
              if (model_hit()) begin
                if (m_lives == 1) begin
                  m_phase = 3; m_lives = 0;
                  if (m_score > m_hi) m_hi = m_score;
                end else begin
                  m_phase = 2; m_lives--; m_timer = 30;
                end
              end
            end else begin
              if (m_timer == 1) m_phase = 1;
              m_timer--;
            end
          end
        end
        if (!start) m_armed = 1;
      end
    end
  end

  // Compare process: every falling edge, DUT against model.
  initial begin
    forever begin
      @(negedge clk);
      check("state",     state,     m_phase);
      check("lives",     lives,     m_lives);
      check("score",     score,     m_score);
      check("game_over", game_over, (m_phase == 0 || m_phase == 3));
      check("hit_flash", hit_flash, (m_phase == 2));
`ifdef HIGH_SCORE_EN
      check("hi_score",  hi_score,  m_hi);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic do_tick();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pass_mtn2();
    mtn2_x = 10'd120; do_tick();
    mtn2_x = 10'd600; do_tick();
  endtask

  task automatic pass_all();
    lava_x = 10'd120; mtn1_x = 10'd120; mtn2_x = 10'd120; do_tick();
    lava_x = 10'd600; mtn1_x = 10'd600; mtn2_x = 10'd600; do_tick();
  endtask

  task automatic pass_lava();
    lava_x = 10'd120; do_tick();
    lava_x = 10'd600; do_tick();
  endtask

  // Lava collision, then lava moved out of the y window and the invulnerability window run out.
  task automatic lose_life();
    lava_x = 10'd165; lava_y = 10'd185; do_tick();
    lava_y = 10'd600; ticks(30);
  endtask

  task automatic safe_field();
    plane_y = 10'd180;
    lava_x = 10'd600; lava_y = 10'd100;
    mtn1_x = 10'd600; mtn1_y = 10'd400;
    mtn2_x = 10'd600; mtn2_y = 10'd400;
  endtask

  task automatic restart_from_over();
    safe_field();
    start = 1'b1; do_tick();
    check("lit_over_to_idle", state, 0);
    do_tick();
    check("lit_idle_held_start", state, 0);
    start = 1'b0; do_tick();
    start = 1'b1; do_tick();
    check("lit_rearm_play", state, 1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0;
    safe_field();
    repeat (3) @(posedge clk);
    #1;
    check("lit_rst_state", state, 0);
    check("lit_rst_lives", lives, 3);
    check("lit_rst_score", score, 0);
    check("lit_rst_game_over", game_over, 1);
    check("lit_rst_hit_flash", hit_flash, 0);
    reset = 1'b0;

    // Start and play with obstacles far away
    start = 1'b1; ticks(5);
    check("lit_t1_state", state, 1);
    check("lit_t1_lives", lives, 3);
    check("lit_t1_score", score, 0);
    check("lit_t1_game_over", game_over, 0);
    start = 1'b0;

    // Lava hit, collisions held through invulnerability
    lava_x = 10'd165; lava_y = 10'd185; do_tick();
    check("lit_t2_state", state, 2);
    check("lit_t2_lives", lives, 2);
    check("lit_t2_flash", hit_flash, 1);
    ticks(29);
    check("lit_t5_still_hit", state, 2);
    check("lit_t5_lives_held", lives, 2);
    lava_x = 10'd600; lava_y = 10'd100; do_tick();
    check("lit_t2_back_play", state, 1);
    check("lit_t2_pass_in_hit", score, 1);

    // Two passes on one tick
    lava_x = 10'd120; mtn2_x = 10'd120; do_tick();
    lava_x = 10'd600; mtn2_x = 10'd600; do_tick();
    check("lit_t4_double_pass", score, 3);

    for (int i = 0; i < 31; i++) pass_all();
    pass_lava();
    pass_lava();
    check("lit_t4_score98", score, 98);
    lava_x = 10'd120; mtn2_x = 10'd120; do_tick();
    lava_x = 10'd600; mtn2_x = 10'd600; do_tick();
    check("lit_t4_saturate", score, 99);
    pass_all();
    check("lit_t4_sat_hold", score, 99);

    // Lose down to one life, then a mountain hit ends the game
    lose_life();
    check("lit_t3_lives1", lives, 1);
    check("lit_t3_play", state, 1);
    mtn1_x = 10'd160; mtn1_y = 10'd150; plane_y = 10'd200; do_tick();
    check("lit_t3_over", state, 3);
    check("lit_t3_lives0", lives, 0);
    check("lit_t3_game_over", game_over, 1);
    mtn1_x = 10'd600; ticks(2);
    check("lit_t3_score_frozen", score, 99);

    // Restart, hit, then reset while in HIT
    restart_from_over();
    pass_mtn2(); pass_mtn2();
    lava_x = 10'd165; lava_y = 10'd185; do_tick();
    ticks(3);
    check("lit_t5_pre_reset_hit", state, 2);
    #2 reset = 1'b1;
    #2;
    check("lit_t5_rst_state", state, 0);
    check("lit_t5_rst_lives", lives, 3);
    check("lit_t5_rst_score", score, 0);
    check("lit_t5_rst_flash", hit_flash, 0);
    safe_field();
    @(posedge clk); #3 reset = 1'b0;

    // Two full games: scores 7 then 4
    start = 1'b1; do_tick();
    check("lit_g1_play", state, 1);
    start = 1'b0;
    for (int i = 0; i < 7; i++) pass_mtn2();
    lose_life(); lose_life(); lose_life();
    check("lit_g1_over", state, 3);
    check("lit_g1_score", score, 7);
`ifdef HIGH_SCORE_EN
    check("lit_g1_hi", hi_score, 7);
`endif
    restart_from_over();
    for (int i = 0; i < 4; i++) pass_mtn2();
    lose_life(); lose_life(); lose_life();
    check("lit_g2_over", state, 3);
    check("lit_g2_score", score, 4);
`ifdef HIGH_SCORE_EN
    check("lit_g2_hi", hi_score, 7);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
